select_sequencer: RTL and testbench
===================================

SELECT_SEQUENCER -- requirements
Module: select_sequencer

Interface
REQ-001 Parameter DWELL_W, default 8: width of the dwell field and of the internal hold counter.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request to begin a sequence; sampled in IDLE only.
REQ-005 stop  input  1  abort request; sampled in RUN and IDLE.
REQ-006 mode  input  1  0 = one-shot (four codes then finish), 1 = continuous (wrap forever).
REQ-007 dir  input  1  0 = ascending order, 1 = descending order.
REQ-008 dwell  input  DWELL_W  hold count; each code is held for dwell+1 cycles.
REQ-009 a  output  1  select MSB, registered, feeds downstream 2-to-4 decoder input a.
REQ-010 b  output  1  select LSB, registered, feeds downstream 2-to-4 decoder input b.
REQ-011 busy  output  1  high while in RUN.
REQ-012 step  output  1  one-cycle pulse in the cycle a/b take a new code within RUN, including the first code.
REQ-013 done  output  1  one-cycle pulse when a one-shot sequence completes normally.

Function
REQ-014 States SHALL be IDLE, RUN, DONE; encoding is implementation choice.
REQ-015 IDLE: {a,b}=00, busy=0, step=0, done=0.
REQ-016 IDLE with start=1 and stop=0 at edge N -> RUN at N+1, {a,b}=first code, busy=1, step=1.
REQ-017 mode, dir, dwell SHALL be captured at the start edge; changes during RUN SHALL be ignored.
REQ-018 First code: 00 when dir=0; last code of the order when dir=1.
REQ-019 Hold counter loads captured dwell on each new code, decrements per cycle; when it equals 0, the next edge advances the code.
REQ-020 dwell=0 SHALL advance the code every cycle (step high each cycle in RUN).
REQ-021 Continuous mode: after the last code, wrap to the first code; step pulses on the wrap.
REQ-022 One-shot mode: when the fourth code's hold expires -> DONE for exactly one cycle with done=1, busy=0, {a,b}=00; then IDLE.
REQ-023 stop=1 in RUN -> IDLE at the next edge, {a,b}=00, no done pulse; stop has priority over hold expiry.
REQ-024 start=1 and stop=1 together in IDLE: stop wins, remain IDLE.
REQ-025 start in RUN or DONE SHALL be ignored; no queuing.
REQ-026 a and b SHALL be driven directly from flops (glitch-free for the decoder).

Reset
REQ-027 rst_n low SHALL immediately force IDLE, {a,b}=00, busy=0, step=0, done=0, hold counter=0, independent of clk.
REQ-028 Reset asserted mid-sequence SHALL abort with no done pulse; after release, a new start is required.

Configuration
REQ-029 Macro SEQ_GRAY_EN defined: ascending order 00,01,11,10 (one bit changes per step, including wrap).
REQ-030 SEQ_GRAY_EN undefined: ascending order 00,01,10,11 (binary).
REQ-031 Descending order SHALL be the exact reverse of the active ascending order in both builds.

Verification
REQ-032 Binary build, mode=0, dir=0, dwell=2, start pulse -> {a,b}=00,01,10,11 each for 3 cycles, step on each change, then done=1 one cycle, {a,b}=00, busy=0.
REQ-033 Gray build, mode=1, dir=1, dwell=0 -> {a,b}=10,11,01,00,10,... changing every cycle, busy held high, done never asserted.
REQ-034 mode=1, dwell=5, stop asserted in 2nd cycle of code 01 -> next cycle {a,b}=00, busy=0, done=0.
REQ-035 start and stop both high in IDLE -> busy stays 0; start alone one cycle later -> busy=1, step=1.
REQ-036 rst_n pulled low between clock edges during RUN -> outputs 00/0 before next edge; dwell changed mid-run has no effect on hold length.

Source files
------------

// File: rtl/select_sequencer.sv
// select_sequencer: steps a 2-bit select code {a,b} through four values
// for a downstream 2-to-4 decoder, holding each code for dwell+1 cycles.
// Ports: clk, rst_n (async, active-low), start, stop, mode (0 one-shot,
// 1 continuous), dir (0 ascending, 1 descending), dwell[DWELL_W-1:0];
// outputs a, b (registered select), busy, step, done (pulses).
// Optional: define SEQ_GRAY_EN for Gray order 00,01,11,10 (else binary).
module select_sequencer #(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               mode,
    input  logic               dir,
    input  logic [DWELL_W-1:0] dwell,
    output logic               a,
    output logic               b,
    output logic               busy,
    output logic               step,
    output logic               done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [1:0]         pos_q, pos_d;
    logic [1:0]         sel_q, sel_d;
    logic [DWELL_W-1:0] hold_q, hold_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic               mode_q, mode_d;
    logic               dir_q, dir_d;
    logic               busy_q, busy_d;
    logic               step_q, step_d;
    logic               done_q, done_d;

    // Position 0..3 within the active order; descending walks the
    // ascending table backwards (3-pos == ~pos for two bits).
    function automatic logic [1:0] code_of(input logic [1:0] pos,
                                           input logic       desc);
        logic [1:0] p;
        p = desc ? ~pos : pos;
`ifdef SEQ_GRAY_EN
        return {p[1], p[1] ^ p[0]};
`else
        return p;
`endif
    endfunction

    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        sel_d   = sel_q;
        hold_d  = hold_q;
        dwell_d = dwell_q;
        mode_d  = mode_q;
        dir_d   = dir_q;
        step_d  = 1'b0;
        done_d  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                sel_d  = 2'b00;
                hold_d = '0;
                if (start && !stop) begin
                    state_d = S_RUN;
                    mode_d  = mode;
                    dir_d   = dir;
                    dwell_d = dwell;
                    pos_d   = 2'd0;
                    sel_d   = code_of(2'd0, dir);
                    hold_d  = dwell;
                    step_d  = 1'b1;
                end
            end
            S_RUN: begin
                if (stop) begin
                    // abort wins over a hold expiring on the same edge
                    state_d = S_IDLE;
                    sel_d   = 2'b00;
                    hold_d  = '0;
                end else if (hold_q == '0) begin
                    if (pos_q == 2'd3 && !mode_q) begin
                        state_d = S_DONE;
                        sel_d   = 2'b00;
                        hold_d  = '0;
                        done_d  = 1'b1;
                    end else begin
                        // pos wraps 3 -> 0 naturally in continuous mode
                        pos_d  = pos_q + 2'd1;
                        sel_d  = code_of(pos_q + 2'd1, dir_q);
                        hold_d = dwell_q;
                        step_d = 1'b1;
                    end
                end else begin
                    hold_d = hold_q - 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                sel_d   = 2'b00;
                hold_d  = '0;
            end
            default: begin
                state_d = S_IDLE;
                sel_d   = 2'b00;
                hold_d  = '0;
            end
        endcase

        busy_d = (state_d == S_RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pos_q   <= 2'd0;
            sel_q   <= 2'b00;
            hold_q  <= '0;
            dwell_q <= '0;
            mode_q  <= 1'b0;
            dir_q   <= 1'b0;
            busy_q  <= 1'b0;
            step_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            sel_q   <= sel_d;
            hold_q  <= hold_d;
            dwell_q <= dwell_d;
            mode_q  <= mode_d;
            dir_q   <= dir_d;
            busy_q  <= busy_d;
            step_q  <= step_d;
            done_q  <= done_d;
        end
    end

    // every output comes straight from a flop
    assign a    = sel_q[1];
    assign b    = sel_q[0];
    assign busy = busy_q;
    assign step = step_q;
    assign done = done_q;

endmodule

// File: tb/tb_select_sequencer.sv
// tb_select_sequencer: directed stimulus with a cycle-count model of the
// select sequence, plus literal expectations at key points.
module tb_select_sequencer;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       stop;
    logic       mode;
    logic       dir;
    logic [7:0] dwell;
    logic       a;
    logic       b;
    logic       busy;
    logic       step;
    logic       done;

    int n_chk = 0;
    int n_bad = 0;

    select_sequencer #(.DWELL_W(8)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .stop (stop),
        .mode (mode),
        .dir  (dir),
        .dwell(dwell),
        .a    (a),
        .b    (b),
        .busy (busy),
        .step (step),
        .done (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ascending order and its hand-written reverse
    logic [1:0] asc [4];
    logic [1:0] dsc [4];
    initial begin
`ifdef SEQ_GRAY_EN
        asc[0] = 2'b00; asc[1] = 2'b01; asc[2] = 2'b11; asc[3] = 2'b10;
        dsc[0] = 2'b10; dsc[1] = 2'b11; dsc[2] = 2'b01; dsc[3] = 2'b00;
`else
        asc[0] = 2'b00; asc[1] = 2'b01; asc[2] = 2'b10; asc[3] = 2'b11;
        dsc[0] = 2'b11; dsc[1] = 2'b10; dsc[2] = 2'b01; dsc[3] = 2'b00;
`endif
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: m_t counts cycles since the start edge; the code index is
    // m_t / (dwell+1), a step happens whenever m_t is a multiple of it.
    int m_st = 0;
    int m_t  = 0;
    int m_L  = 1;
    bit m_mode;
    bit m_dir;

    always @(posedge clk or negedge rst_n) begin
        int nt;
        if (!rst_n) begin
            m_st <= 0;
            m_t  <= 0;
        end else begin
            case (m_st)
                0: if (start && !stop) begin
                    m_st   <= 1;
                    m_t    <= 0;
                    m_L    <= int'(dwell) + 1;
                    m_mode <= mode;
                    m_dir  <= dir;
                end
                1: if (stop) begin
                    m_st <= 0;
                end else begin
                    nt = m_t + 1;
                    if (nt == 4 * m_L) begin
                        if (m_mode) m_t <= 0;
                        else m_st <= 2;
                    end else begin
                        m_t <= nt;
                    end
                end
                default: m_st <= 0;
            endcase
        end
    end

    always @(negedge clk) begin
        int pos;
        logic [1:0] e_ab;
        e_ab = 2'b00;
        if (m_st == 1) begin
            pos  = m_t / m_L;
            e_ab = m_dir ? asc[3 - pos] : asc[pos];
        end
        chk("m_ab", int'({a, b}), int'(e_ab));
        chk("m_busy", int'(busy), (m_st == 1) ? 1 : 0);
        chk("m_step", int'(step),
            (m_st == 1 && (m_t % m_L) == 0) ? 1 : 0);
        chk("m_done", int'(done), (m_st == 2) ? 1 : 0);
    end

    task automatic cyc();
        @(negedge clk);
        #2;
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        mode  = 1'b0;
        dir   = 1'b0;
        dwell = 8'd0;
        cyc();
        cyc();
        chk("rst_ab", int'({a, b}), 0);
        chk("rst_flags", int'({busy, step, done}), 0);
        rst_n = 1'b1;
        cyc();
        chk("idle_busy", int'(busy), 0);

        // one-shot ascending, dwell=2
        mode = 1'b0; dir = 1'b0; dwell = 8'd2; start = 1'b1;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (i < 12) begin
                chk("os_ab", int'({a, b}), int'(asc[i / 3]));
                chk("os_step", int'(step), (i % 3 == 0) ? 1 : 0);
                chk("os_busy", int'(busy), 1);
            end else if (i == 12) begin
                chk("os_done", int'(done), 1);
                chk("os_done_ab", int'({a, b, busy}), 0);
            end else begin
                chk("os_idle", int'({done, busy}), 0);
            end
            #2 start = 1'b0;
        end

        // continuous descending, dwell=0
        cyc();
        mode = 1'b1; dir = 1'b1; dwell = 8'd0; start = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("cd_ab", int'({a, b}), int'(dsc[i % 4]));
            chk("cd_flags", int'({busy, step, done}), 3'b110);
            #2 start = 1'b0;
        end
        stop = 1'b1;
        @(negedge clk);
        chk("cd_stop", int'({a, b, busy, done}), 0);
        #2 stop = 1'b0;

        // stop in 2nd cycle of code 01, dwell=5
        cyc();
        mode = 1'b1; dir = 1'b0; dwell = 8'd5; start = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            #2 start = 1'b0;
        end
        chk("st_pre_ab", int'({a, b}), 1);
        stop = 1'b1;
        @(negedge clk);
        chk("st_ab", int'({a, b}), 0);
        chk("st_flags", int'({busy, done}), 0);
        #2 stop = 1'b0;

        // start+stop together, then start alone
        cyc();
        mode = 1'b0; dir = 1'b0; dwell = 8'd0;
        start = 1'b1; stop = 1'b1;
        @(negedge clk);
        chk("ss_busy", int'(busy), 0);
        #2 stop = 1'b0;
        @(negedge clk);
        chk("ss_go", int'({busy, step}), 2'b11);
        #2 start = 1'b0;
        repeat (6) cyc();

        // dwell change ignored, then async reset mid-run
        mode = 1'b1; dir = 1'b0; dwell = 8'd3; start = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("dw_ab", int'({a, b}), (i < 4) ? 0 : 1);
            if (i == 0) begin
                #2 start = 1'b0;
                dwell = 8'd0;
            end
        end
        #2 rst_n = 1'b0;
        #1;
        chk("ar_ab", int'({a, b}), 0);
        chk("ar_flags", int'({busy, step, done}), 0);
        cyc();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("ar_stay", int'(busy), 0);
        end

        // one-shot descending dwell=1 with start held throughout
        cyc();
        mode = 1'b0; dir = 1'b1; dwell = 8'd1; start = 1'b1;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            if (i == 4) begin
                chk("sh_ab", int'({a, b}), 1);
                chk("sh_step", int'(step), 1);
            end
            if (i == 8) chk("sh_done", int'(done), 1);
            if (i == 9) chk("sh_ign", int'(busy), 0);
            if (i == 10) chk("sh_rst", int'({busy, step}), 2'b11);
        end
        #2 start = 1'b0;
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        repeat (3) cyc();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
